// File: rtl/max_reduce_pipe_if.sv
// Vector-in / extremum-out handshake bundle for max_reduce_pipe.
interface max_reduce_pipe_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
);
  localparam int unsigned IDX_W = $clog2(N);

  logic               valid_in;
  logic               ready_in;
  logic               mode_min;
  logic [N*W-1:0]     data_in;
  logic               ready_out;
  logic               valid_out;
  logic [W-1:0]       ext_out;
  logic [IDX_W-1:0]   idx_out;

  modport master (
    output valid_in, mode_min, data_in, ready_out,
    input  ready_in, valid_out, ext_out, idx_out
  );

  modport slave (
    input  valid_in, mode_min, data_in, ready_out,
    output ready_in, valid_out, ext_out, idx_out
  );
endinterface

// File: rtl/max_reduce_pipe.sv
// Pipelined max/min reduction tree with argmax/argmin index and valid/ready backpressure.
// One tree level per register stage; whole pipe freezes while the result is not taken.
module max_reduce_pipe #(
  parameter int unsigned N      = 8,
  parameter int unsigned W      = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  max_reduce_pipe_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned L     = $clog2(N);
  localparam int unsigned NODES = N - 1;

  // Heap-style flat tree: positions 0..N-1 are the lanes, node j sits at N+j
  // and its children are at 2j and 2j+1; the root is position 2N-2.
  logic [NODES*W-1:0]         node_val_q;
  logic [NODES*W-1:0]         node_val_nxt;
  logic [NODES*IDX_W-1:0]     node_idx_q;
  logic [NODES*IDX_W-1:0]     node_idx_nxt;
  logic [N*IDX_W-1:0]         lane_idx;
  logic [(2*N-1)*W-1:0]       tree_val;
  logic [(2*N-1)*IDX_W-1:0]   tree_idx;
  logic [L-1:0]               vld_q;
  logic [L-1:0]               mode_lvl;
  logic                       stall;

  function automatic logic b_wins(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic mn);
    logic gt;
    logic lt;
    if (SIGNED) begin
      gt = $signed(b) > $signed(a);
      lt = $signed(b) < $signed(a);
    end else begin
      gt = b > a;
      lt = b < a;
    end
    return mn ? lt : gt;
  endfunction

  assign stall         = vld_q[L-1] & ~bus.ready_out;
  assign bus.ready_in  = ~stall;
  assign bus.valid_out = vld_q[L-1];
  assign bus.ext_out   = tree_val[(2*N-2)*W +: W];
  assign bus.idx_out   = tree_idx[(2*N-2)*IDX_W +: IDX_W];

  assign tree_val = {node_val_q, bus.data_in};
  assign tree_idx = {node_idx_q, lane_idx};

  always_comb begin
    lane_idx = '0;
    for (int k = 0; k < int'(N); k++) begin
      lane_idx[k*IDX_W +: IDX_W] = IDX_W'(k);
    end
  end

  // Mode bit travelling alongside the vector; level s compares with mode_lvl[s-1].
  if (L > 1) begin : g_mode
    logic [L-2:0] mode_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mode_q <= '0;
      end else if (!stall) begin
        mode_q[0] <= bus.mode_min;
        for (int s = 1; s < int'(L) - 1; s++) begin
          mode_q[s] <= mode_q[s-1];
        end
      end
    end

    assign mode_lvl = {mode_q, bus.mode_min};
  end else begin : g_mode_one
    assign mode_lvl = bus.mode_min;
  end

  // Next value of every tree node; on ties the lower-index operand a is kept.
  always_comb begin
    int unsigned j;
    logic [W-1:0] a;
    logic [W-1:0] b;
    node_val_nxt = '0;
    node_idx_nxt = '0;
    j = 0;
    a = '0;
    b = '0;
    for (int s = 1; s <= int'(L); s++) begin
      for (int k = 0; k < int'(N >> s); k++) begin
        j = (N - 2 * (N >> s)) + k;
        a = tree_val[(2*j)*W +: W];
        b = tree_val[(2*j+1)*W +: W];
        if (b_wins(a, b, mode_lvl[s-1])) begin
          node_val_nxt[j*W +: W]         = b;
          node_idx_nxt[j*IDX_W +: IDX_W] = tree_idx[(2*j+1)*IDX_W +: IDX_W];
        end else begin
          node_val_nxt[j*W +: W]         = a;
          node_idx_nxt[j*IDX_W +: IDX_W] = tree_idx[(2*j)*IDX_W +: IDX_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      node_val_q <= '0;
      node_idx_q <= '0;
      vld_q      <= '0;
    end else if (!stall) begin
      node_val_q <= node_val_nxt;
      node_idx_q <= node_idx_nxt;
      vld_q[0]   <= bus.valid_in;
      for (int s = 1; s < int'(L); s++) begin
        vld_q[s] <= vld_q[s-1];
      end
    end
  end
endmodule

// File: tb/tb_max_reduce_pipe.sv
// Scoreboard bench: a signed and an unsigned build see the same directed vectors.
module tb_max_reduce_pipe;
  localparam int unsigned N = 8;
  localparam int unsigned W = 8;
  localparam int NV = 9;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  max_reduce_pipe_if #(.N(N), .W(W)) s_if ();
  max_reduce_pipe_if #(.N(N), .W(W)) u_if ();

  assign u_if.valid_in  = s_if.valid_in;
  assign u_if.mode_min  = s_if.mode_min;
  assign u_if.data_in   = s_if.data_in;
  assign u_if.ready_out = s_if.ready_out;

  max_reduce_pipe #(.N(N), .W(W), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .bus(s_if.slave));
  max_reduce_pipe #(.N(N), .W(W), .SIGNED(1'b0)) u_dut_u (.clk(clk), .rst(rst), .bus(u_if.slave));

  logic [63:0] vd [NV];
  logic        vm [NV];
  logic [10:0] es [NV];
  logic [10:0] eu [NV];
  logic [10:0] q_s [$];
  logic [10:0] q_u [$];

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3,
                                     input int l4, input int l5, input int l6, input int l7);
    return {8'(l7), 8'(l6), 8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  function automatic logic [10:0] ex(input logic [7:0] v, input int i);
    return {v, 3'(i)};
  endfunction

  // Offer vector k until accepted; expected results are queued at acceptance.
  task automatic send(input int k);
    int w;
    s_if.valid_in = 1'b1;
    s_if.data_in  = vd[k];
    s_if.mode_min = vm[k];
    w = 0;
    @(negedge clk);
    while (!s_if.ready_in && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!s_if.ready_in) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout vector %0d never accepted", k);
    end else begin
      q_s.push_back(es[k]);
      q_u.push_back(eu[k]);
    end
    @(posedge clk);
    #1;
    s_if.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int w;
    w = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && w < 40) begin
      @(posedge clk);
      w++;
    end
    #1;
    checks++;
    if (q_s.size() != 0 || q_u.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d/%0d results outstanding, need 0", q_s.size(), q_u.size());
    end
  endtask

  task automatic check_rst(input string tag);
    checks++;
    if ({s_if.valid_out, s_if.ext_out, s_if.idx_out, s_if.ready_in} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL %s_signed got v=%b e=%h i=%0d r=%b need v=0 e=00 i=0 r=1", tag,
               s_if.valid_out, s_if.ext_out, s_if.idx_out, s_if.ready_in);
    end
    checks++;
    if ({u_if.valid_out, u_if.ext_out, u_if.idx_out, u_if.ready_in} !== {1'b0, 8'h00, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL %s_unsigned got v=%b e=%h i=%0d r=%b need v=0 e=00 i=0 r=1", tag,
               u_if.valid_out, u_if.ext_out, u_if.idx_out, u_if.ready_in);
    end
  endtask

  // Monitor: compare every presented result with the queue head, pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (s_if.ready_in !== !(s_if.valid_out && !s_if.ready_out)) begin
        errors++;
        $display("FAIL ready_in_signed got %b need %b", s_if.ready_in, !(s_if.valid_out && !s_if.ready_out));
      end
      if (s_if.valid_out) begin
        checks++;
        if (q_s.size() == 0) begin
          errors++;
          $display("FAIL unexpected_signed got e=%h i=%0d need no result", s_if.ext_out, s_if.idx_out);
        end else begin
          if ({s_if.ext_out, s_if.idx_out} !== q_s[0]) begin
            errors++;
            $display("FAIL result_signed got e=%h i=%0d need e=%h i=%0d",
                     s_if.ext_out, s_if.idx_out, q_s[0][10:3], q_s[0][2:0]);
          end
          if (s_if.ready_out) void'(q_s.pop_front());
        end
      end
      if (u_if.valid_out) begin
        checks++;
        if (q_u.size() == 0) begin
          errors++;
          $display("FAIL unexpected_unsigned got e=%h i=%0d need no result", u_if.ext_out, u_if.idx_out);
        end else begin
          if ({u_if.ext_out, u_if.idx_out} !== q_u[0]) begin
            errors++;
            $display("FAIL result_unsigned got e=%h i=%0d need e=%h i=%0d",
                     u_if.ext_out, u_if.idx_out, q_u[0][10:3], q_u[0][2:0]);
          end
          if (u_if.ready_out) void'(q_u.pop_front());
        end
      end
    end
  end

  initial begin
    int w;
    clk = 1'b0;
    rst = 1'b0;
    checks = 0;
    errors = 0;
    s_if.valid_in  = 1'b0;
    s_if.mode_min  = 1'b0;
    s_if.data_in   = '0;
    s_if.ready_out = 1'b1;

    vd[0] = pk(-50, -20, -100, -5, -30, -90, -10, -60); vm[0] = 1'b0; es[0] = ex(8'hFB, 3); eu[0] = ex(8'hFB, 3);
    vd[1] = pk(-128, 0, 50, 120, -100, 50, 120, 127);   vm[1] = 1'b0; es[1] = ex(8'h7F, 7); eu[1] = ex(8'h9C, 4);
    vd[2] = vd[1];                                       vm[2] = 1'b1; es[2] = ex(8'h80, 0); eu[2] = ex(8'h00, 1);
    vd[3] = pk(30, 50, -80, 120, 0, 60, 70, 120);       vm[3] = 1'b0; es[3] = ex(8'h78, 3); eu[3] = ex(8'hB0, 2);
    vd[4] = pk(7, 7, 7, 7, 7, 7, 7, 7);                 vm[4] = 1'b1; es[4] = ex(8'h07, 0); eu[4] = ex(8'h07, 0);
    vd[5] = pk(127, 127, 127, 127, 127, 128, 127, 127); vm[5] = 1'b0; es[5] = ex(8'h7F, 0); eu[5] = ex(8'h80, 5);
    vd[6] = pk(255, 0, 16, 16, 16, 16, 16, 16);         vm[6] = 1'b1; es[6] = ex(8'hFF, 0); eu[6] = ex(8'h00, 1);
    vd[7] = pk(5, 3, 9, 3, 8, 3, 4, 6);                 vm[7] = 1'b1; es[7] = ex(8'h03, 1); eu[7] = ex(8'h03, 1);
    vd[8] = pk(10, 20, 30, 40, 50, 60, 70, -128);       vm[8] = 1'b1; es[8] = ex(8'h80, 7); eu[8] = ex(8'h0A, 0);

    // reset state
    repeat (2) @(negedge clk);
    check_rst("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // single all-negative vector, then silence: a second valid cycle would be unexpected
    send(0);
    idle(6);

    // back-to-back max then min on the same lanes
    send(1);
    send(2);
    drain();

    // ties and lane-boundary winners streamed
    send(3);
    send(4);
    send(7);
    send(8);
    send(5);
    send(6);
    drain();

    // backpressure: hold the first result for 4 cycles while a 4th vector waits
    fork
      begin
        send(0);
        send(1);
        send(2);
        send(3);
      end
      begin
        w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!s_if.valid_out && w < 30);
        if (!s_if.valid_out) begin
          checks++;
          errors++;
          $display("FAIL bp_wait got no valid_out within %0d cycles", w);
        end
        s_if.ready_out = 1'b0;
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (s_if.ready_in !== 1'b0 || s_if.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got ready_in=%b valid_out=%b need 0/1", s_if.ready_in, s_if.valid_out);
          end
        end
        @(posedge clk);
        #1;
        s_if.ready_out = 1'b1;
      end
    join
    drain();

    // reset with two vectors in flight, then one fresh vector
    send(4);
    send(7);
    rst = 1'b0;
    @(negedge clk);
    check_rst("midreset");
    q_s.delete();
    q_u.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    send(3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
